pq_cmd_sched: RTL and testbench

- Upstream command scheduler for the priority-queue blocks.
- Buffers enqueue/dequeue/replace commands from a valid/ready producer in a small FIFO.
- Issues each command to the PQ as a single-cycle enq/deq pulse, honouring busy/full/empty.
- Returns dequeued key-value pairs on a valid/ready response port; PQ-side ports attach to the pq_if signals.

---
 rtl/pq_cmd_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_pq_cmd_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_sched.sv
// pq_cmd_sched: upstream command scheduler for the priority-queue blocks.
// Commands (ENQ/DEQ/REPLACE) from a valid/ready producer are buffered in a
// small FIFO and issued to the PQ as single-cycle enq/deq pulses. Dequeued
// pairs come back on a valid/ready response port.
// Optional feature: define PQ_CMD_STATS_EN to add saturating 16-bit
// statistics outputs stat_enq, stat_deq and stat_err.
module pq_cmd_sched #(
   parameter int KEY_WIDTH  = 8,
   parameter int VAL_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] cmd_kv,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] rsp_kv,
   output logic                           rsp_empty,
   output logic                           err,
   output logic                           pq_enq,
   output logic                           pq_deq,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
   input  logic                           pq_busy,
   input  logic                           pq_full,
   input  logic                           pq_empty
`ifdef PQ_CMD_STATS_EN
   ,
   output logic [15:0]                    stat_enq,
   output logic [15:0]                    stat_deq,
   output logic [15:0]                    stat_err
`endif
);

   localparam int KVW = KEY_WIDTH + VAL_WIDTH;
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [1:0]  OP_NOP  = 2'b00;
   localparam logic [1:0]  OP_ENQ  = 2'b01;
   localparam logic [1:0]  OP_DEQ  = 2'b10;
   localparam logic [1:0]  OP_REP  = 2'b11;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT
   } state_t;

   // Command FIFO storage; data only, so no reset needed.
   logic [1:0]     op_mem [FIFO_DEPTH];
   logic [KVW-1:0] kv_mem [FIFO_DEPTH];

   // Extra pointer MSB distinguishes full from empty.
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           go;
   logic           rsp_take;
   logic [1:0]     head_op;
   logic [KVW-1:0] head_kv;

   state_t         state_q;
   logic           pq_enq_q;
   logic           pq_deq_q;
   logic [KVW-1:0] pq_kvi_q;
   logic           err_q;
   logic           rsp_valid_q;
   logic [KVW-1:0] rsp_kv_q;
   logic           rsp_empty_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cmd_ready  = !fifo_full;

   // NOPs complete the handshake but are never stored.
   assign push     = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
   assign head_op  = op_mem[rd_ptr_q[AW-1:0]];
   assign head_kv  = kv_mem[rd_ptr_q[AW-1:0]];
   assign rsp_take = rsp_valid_q && rsp_ready;

   // Issue decision: ENQ never waits on the response port; DEQ/REPLACE need
   // the response slot free (or freed this cycle) so no response is lost.
   assign go = (state_q == S_IDLE) && !fifo_empty && !pq_busy &&
               ((head_op == OP_ENQ) || !rsp_valid_q || rsp_take);

   assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
   assign rd_ptr_d = go   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   // Write accepted commands into the FIFO storage.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr_q[AW-1:0]] <= cmd_op;
         kv_mem[wr_ptr_q[AW-1:0]] <= cmd_kv;
      end
   end

   // FIFO pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Scheduler FSM with registered PQ pulses, error pulse and response slot.
   // The issue decision is taken in IDLE, where the PQ is idle and its
   // flags are stable, so the pulses appear during the ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pq_enq_q    <= 1'b0;
         pq_deq_q    <= 1'b0;
         pq_kvi_q    <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_kv_q    <= '0;
         rsp_empty_q <= 1'b0;
      end else begin
         pq_enq_q <= 1'b0;
         pq_deq_q <= 1'b0;
         err_q    <= 1'b0;
         if (rsp_take) begin
            rsp_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q  <= S_ISSUE;
                  pq_kvi_q <= head_kv;
                  case (head_op)
                     OP_ENQ: begin
                        if (pq_full) begin
                           err_q <= 1'b1;
                        end else begin
                           pq_enq_q <= 1'b1;
                        end
                     end
                     OP_DEQ: begin
                        rsp_valid_q <= 1'b1;
                        if (pq_empty) begin
                           rsp_kv_q    <= '0;
                           rsp_empty_q <= 1'b1;
                        end else begin
                           pq_deq_q    <= 1'b1;
                           rsp_kv_q    <= pq_kvo;
                           rsp_empty_q <= 1'b0;
                        end
                     end
                     OP_REP: begin
                        // An empty PQ cannot be full, so the insert always goes.
                        pq_enq_q    <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (pq_empty) begin
                           rsp_kv_q    <= '0;
                           rsp_empty_q <= 1'b1;
                        end else begin
                           pq_deq_q    <= 1'b1;
                           rsp_kv_q    <= pq_kvo;
                           rsp_empty_q <= 1'b0;
                        end
                     end
                     default: begin
                        state_q <= S_IDLE;
                     end
                  endcase
               end
            end
            S_ISSUE: begin
               state_q <= (pq_enq_q || pq_deq_q) ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: begin
               // The PQ raises busy one cycle after a pulse; skip that cycle.
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (!pq_busy) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pq_enq    = pq_enq_q;
   assign pq_deq    = pq_deq_q;
   assign pq_kvi    = pq_kvi_q;
   assign err       = err_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_kv    = rsp_kv_q;
   assign rsp_empty = rsp_empty_q;

`ifdef PQ_CMD_STATS_EN
   logic [15:0] stat_enq_q;
   logic [15:0] stat_deq_q;
   logic [15:0] stat_err_q;
   logic        enq_evt;
   logic        deq_evt;
   logic        err_evt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Events mirror the issue decision; a dropped ENQ and an empty response
   // are mutually exclusive, so one increment covers both.
   assign enq_evt = go && (((head_op == OP_ENQ) && !pq_full) || (head_op == OP_REP));
   assign deq_evt = go && (head_op != OP_ENQ) && !pq_empty;
   assign err_evt = go && (((head_op == OP_ENQ) && pq_full) ||
                           ((head_op != OP_ENQ) && pq_empty));

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_enq_q <= '0;
         stat_deq_q <= '0;
         stat_err_q <= '0;
      end else begin
         if (enq_evt) stat_enq_q <= sat_inc(stat_enq_q);
         if (deq_evt) stat_deq_q <= sat_inc(stat_deq_q);
         if (err_evt) stat_err_q <= sat_inc(stat_err_q);
      end
   end

   assign stat_enq = stat_enq_q;
   assign stat_deq = stat_deq_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_pq_cmd_sched.sv
// Bench for pq_cmd_sched: a small sorted-array PQ model (capacity 4, busy
// two cycles after a one-cycle lag) sits on the PQ side; directed command
// sequences with hand-computed responses.
module tb_pq_cmd_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_kv;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_kv;
   logic        rsp_empty;
   logic        err;
   logic        pq_enq;
   logic        pq_deq;
   logic [15:0] pq_kvi;
   logic [15:0] pq_kvo;
   logic        pq_busy;
   logic        pq_full;
   logic        pq_empty;

   localparam logic [1:0] ENQ = 2'b01;
   localparam logic [1:0] DEQ = 2'b10;
   localparam logic [1:0] REP = 2'b11;

   pq_cmd_sched #(.KEY_WIDTH(8), .VAL_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_empty(rsp_empty),
      .err(err), .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
   );

   always #5 clk = ~clk;

   // ---------------- PQ model ----------------
   logic [15:0] m_mem [4];
   int          m_cnt;
   logic [3:0]  busy_sr;
   int          pos_all;
   int          pos_rep;

   assign pq_kvo   = (m_cnt != 0) ? m_mem[0] : 16'h0000;
   assign pq_empty = (m_cnt == 0);
   assign pq_full  = (m_cnt == 4);
   assign pq_busy  = busy_sr[0];

   always_comb begin
      pos_all = 0;
      pos_rep = 0;
      for (int i = 0; i < 4; i++) begin
         if (i < m_cnt && m_mem[i][15:8] <= pq_kvi[15:8]) pos_all++;
         if (i >= 1 && i < m_cnt && m_mem[i][15:8] <= pq_kvi[15:8]) pos_rep++;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt   <= 0;
         busy_sr <= 4'b0000;
      end else begin
         busy_sr <= busy_sr >> 1;
         if (pq_enq || pq_deq) busy_sr <= 4'b0110;
         if (pq_enq && pq_deq) begin
            for (int i = 0; i < 4; i++) begin
               if (i < pos_rep) m_mem[i] <= m_mem[(i + 1) % 4];
               else if (i == pos_rep) m_mem[i] <= pq_kvi;
            end
         end else if (pq_enq && m_cnt < 4) begin
            for (int i = 0; i < 4; i++) begin
               if (i == pos_all) m_mem[i] <= pq_kvi;
               else if (i > pos_all) m_mem[i] <= m_mem[(i + 3) % 4];
            end
            m_cnt <= m_cnt + 1;
         end else if (pq_deq && m_cnt > 0) begin
            for (int i = 0; i < 4; i++) m_mem[i] <= m_mem[(i + 1) % 4];
            m_cnt <= m_cnt - 1;
         end
      end
   end

   // ---------------- monitor ----------------
   int          n_enq = 0;
   int          n_deq = 0;
   int          n_both = 0;
   int          err_pulses = 0;
   int          cyc = 0;
   int          last_p = 0;
   bit          have_p = 1'b0;
   int          min_sp = 1000;
   logic [16:0] rsp_q [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (pq_enq) n_enq <= n_enq + 1;
         if (pq_deq) n_deq <= n_deq + 1;
         if (pq_enq && pq_deq) n_both <= n_both + 1;
         if (err) err_pulses <= err_pulses + 1;
         if (pq_enq || pq_deq) begin
            if (have_p && (cyc - last_p) < min_sp) min_sp <= cyc - last_p;
            last_p <= cyc;
            have_p <= 1'b1;
         end
         if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_empty, rsp_kv});
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] kv(input logic [7:0] k);
      return {k, k ^ 8'h5A};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic push_cmd(input logic [1:0] op, input logic [15:0] v);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_kv    = v;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_kv    = 16'h0000;
   endtask

   task automatic expect_rsp(input string tag, input logic e, input logic [15:0] k);
      int n = 0;
      logic [16:0] r;
      while (rsp_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (rsp_q.size() == 0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         r = rsp_q.pop_front();
         check({tag, "_kv"}, {16'h0, r[15:0]}, {16'h0, k});
         check({tag, "_empty"}, {31'h0, r[16]}, {31'h0, e});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int base_enq, base_deq, base_both, base_err;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_kv    = 16'h0000;
      rsp_ready = 1'b1;
      idle(3);
      // Reset state
      check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("rst_pulses", {30'h0, pq_enq, pq_deq}, 32'd0);
      check("rst_err", {31'h0, err}, 32'd0);
      check("rst_rsp_kv", {16'h0, rsp_kv}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Ordered dequeue: ENQ 5,3,9 then DEQ x3
      push_cmd(ENQ, kv(8'd5));
      push_cmd(ENQ, kv(8'd3));
      push_cmd(ENQ, kv(8'd9));
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      expect_rsp("order0", 1'b0, kv(8'd3));
      expect_rsp("order1", 1'b0, kv(8'd5));
      expect_rsp("order2", 1'b0, kv(8'd9));
      idle(10);
      check("order_enq_count", n_enq, 32'd3);
      check("pulse_spacing_ge3", {31'h0, (min_sp >= 3)}, 32'd1);

      // DEQ on empty PQ
      base_deq = n_deq;
      push_cmd(DEQ, 16'h0);
      expect_rsp("empty_deq", 1'b1, 16'h0000);
      idle(10);
      check("empty_no_pq_deq", n_deq - base_deq, 32'd0);
      check("empty_single_rsp", rsp_q.size(), 32'd0);

      // Fill to capacity, then ENQ into full PQ
      base_enq = n_enq;
      base_err = err_pulses;
      push_cmd(ENQ, kv(8'd8));
      push_cmd(ENQ, kv(8'd6));
      push_cmd(ENQ, kv(8'd7));
      push_cmd(ENQ, kv(8'd4));
      push_cmd(ENQ, kv(8'd1));
      idle(25);
      check("full_err_once", err_pulses - base_err, 32'd1);
      check("full_no_extra_enq", n_enq - base_enq, 32'd4);
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      expect_rsp("full_min", 1'b0, kv(8'd4));
      expect_rsp("full_d1", 1'b0, kv(8'd6));
      expect_rsp("full_d2", 1'b0, kv(8'd7));
      expect_rsp("full_d3", 1'b0, kv(8'd8));
      idle(10);

      // Backpressure on the response port
      rsp_ready = 1'b0;
      push_cmd(ENQ, kv(8'd10));
      push_cmd(ENQ, kv(8'd11));
      base_deq = n_deq;
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      idle(30);
      check("bp_one_deq", n_deq - base_deq, 32'd1);
      check("bp_rsp_held", {31'h0, rsp_valid}, 32'd1);
      check("bp_rsp_kv_stable", {16'h0, rsp_kv}, {16'h0, kv(8'd10)});
      rsp_ready = 1'b1;
      expect_rsp("bp_r0", 1'b0, kv(8'd10));
      expect_rsp("bp_r1", 1'b0, kv(8'd11));
      idle(10);
      check("bp_two_deq", n_deq - base_deq, 32'd2);

      // REPLACE on {2,7}
      base_both = n_both;
      push_cmd(ENQ, kv(8'd2));
      push_cmd(ENQ, kv(8'd7));
      push_cmd(REP, kv(8'd4));
      push_cmd(DEQ, 16'h0);
      push_cmd(DEQ, 16'h0);
      expect_rsp("rep_old_min", 1'b0, kv(8'd2));
      expect_rsp("rep_next", 1'b0, kv(8'd4));
      expect_rsp("rep_last", 1'b0, kv(8'd7));
      idle(10);
      check("rep_both_once", n_both - base_both, 32'd1);
      check("spacing_all_ge3", {31'h0, (min_sp >= 3)}, 32'd1);

      // Asynchronous reset during WAIT with a response held
      rsp_ready = 1'b0;
      push_cmd(DEQ, 16'h0);
      idle(4);
      check("pre_rst_rsp_held", {31'h0, rsp_valid}, 32'd1);
      push_cmd(ENQ, kv(8'd3));
      begin
         int n = 0;
         while (!pq_enq && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("pre_rst_enq_seen", {31'h0, pq_enq}, 32'd1);
      end
      @(negedge clk);          // SETTLE
      cmd_valid = 1'b1;
      cmd_op    = DEQ;
      cmd_kv    = 16'h0;
      @(negedge clk);          // WAIT, DEQ now in the FIFO
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      base_enq  = n_enq;
      base_deq  = n_deq;
      #2 rst_n = 1'b0;
      #1;
      check("arst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      check("arst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("arst_rsp_empty", {31'h0, rsp_empty}, 32'd0);
      check("arst_pulses_err", {29'h0, pq_enq, pq_deq, err}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      idle(12);
      check("arst_fifo_empty_rsp", rsp_q.size(), 32'd0);
      check("arst_no_pulses", (n_enq - base_enq) + (n_deq - base_deq), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
